// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: word fetch over req/gnt/rvalid into a small FIFO, realigned into
// 16/32-bit instructions at halfword PCs and handed to decode via valid/ready.
module fetch_unit #(
    parameter int RISCV_ADDR_WIDTH = 32,
    parameter int RISCV_WORD_WIDTH = 32,
    parameter logic [RISCV_ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        instr_req_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_mem_addr_o,
    input  logic                        instr_gnt_i,
    input  logic                        instr_rvalid_i,
    input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
    output logic [RISCV_WORD_WIDTH-1:0] instr_o,
    output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
    output logic                        instr_valid_o,
    input  logic                        instr_ready_i,
    input  logic                        jump_i,
    input  logic [RISCV_ADDR_WIDTH-1:0] jump_target_i
);

    localparam int HALF  = RISCV_WORD_WIDTH / 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [RISCV_ADDR_WIDTH-1:0] HALF_MASK = {{(RISCV_ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [RISCV_ADDR_WIDTH-1:0] WORD_MASK = {{(RISCV_ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [RISCV_ADDR_WIDTH-1:0] RESET_FA  = RESET_ADDR & WORD_MASK;

    logic [RISCV_ADDR_WIDTH-1:0] fa;
    logic [RISCV_ADDR_WIDTH-1:0] pc;
    logic [RISCV_WORD_WIDTH-1:0] buf_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]            rd_ptr;
    logic [PTR_W-1:0]            wr_ptr;
    logic [CNT_W-1:0]            count;
    logic                        outstanding;
    logic                        discard;

    logic [RISCV_WORD_WIDTH-1:0] head;
    logic [HALF-1:0]             next_lo;
    logic                        valid;
    logic [RISCV_WORD_WIDTH-1:0] instr;
    logic                        pop;
    logic                        step4;
    logic                        consume;
    logic                        pop_en;
    logic                        req_fire;
    logic                        accept;
    logic                        push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign head    = buf_mem[rd_ptr];
    assign next_lo = buf_mem[ptr_inc(rd_ptr)][HALF-1:0];

    // Realignment: PC[1] selects which half of the head word starts the instruction.
    always_comb begin
        valid = 1'b0;
        instr = '0;
        pop   = 1'b0;
        step4 = 1'b0;
        if (count != '0) begin
            if (!pc[1]) begin
                valid = 1'b1;
                if (head[1:0] != 2'b11) begin
                    instr = {{HALF{1'b0}}, head[HALF-1:0]};
                end else begin
                    instr = head;
                    pop   = 1'b1;
                    step4 = 1'b1;
                end
            end else if (head[HALF+1:HALF] != 2'b11) begin
                valid = 1'b1;
                instr = {{HALF{1'b0}}, head[RISCV_WORD_WIDTH-1:HALF]};
                pop   = 1'b1;
            end else if (count >= CNT_W'(2)) begin
                valid = 1'b1;
                instr = {next_lo, head[RISCV_WORD_WIDTH-1:HALF]};
                pop   = 1'b1;
                step4 = 1'b1;
            end
        end
    end

    assign instr_valid_o    = valid;
    assign instr_o          = instr;
    assign instr_addr_o     = pc;
    assign instr_mem_addr_o = fa;
    assign instr_req_o      = rst_n && !outstanding && (count < FULL_CNT) && !jump_i;

    assign consume  = valid && instr_ready_i && !jump_i;
    assign pop_en   = consume && pop;
    assign req_fire = instr_req_o && instr_gnt_i;
    assign accept   = instr_rvalid_i && outstanding;
    assign push     = accept && !discard && !jump_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_ADDR;
            fa          <= RESET_FA;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
        end else if (jump_i) begin
            pc     <= jump_target_i & HALF_MASK;
            fa     <= jump_target_i & WORD_MASK;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // A word still in flight belongs to the old stream and must be dropped.
            if (accept) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end else if (outstanding) begin
                discard <= 1'b1;
            end
        end else begin
            if (req_fire) begin
                outstanding <= 1'b1;
                fa          <= fa + RISCV_ADDR_WIDTH'(4);
            end
            if (accept) begin
                outstanding <= 1'b0;
                discard     <= 1'b0;
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_en) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (consume) begin
                pc <= pc + RISCV_ADDR_WIDTH'(step4 ? 4 : 2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= instr_rdata_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed scenarios plus randomized memory/decode timing, checked
// against a halfword-level model of the instruction stream held in bench memory.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        instr_req_o;
    logic [31:0] instr_mem_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_addr_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        jump_i;
    logic [31:0] jump_target_i;

    fetch_unit #(
        .RISCV_ADDR_WIDTH (32),
        .RISCV_WORD_WIDTH (32),
        .RESET_ADDR       (RST_PC),
        .FIFO_DEPTH       (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_req_o      (instr_req_o),
        .instr_mem_addr_o (instr_mem_addr_o),
        .instr_gnt_i      (instr_gnt_i),
        .instr_rvalid_i   (instr_rvalid_i),
        .instr_rdata_i    (instr_rdata_i),
        .instr_o          (instr_o),
        .instr_addr_o     (instr_addr_o),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .jump_i           (jump_i),
        .jump_target_i    (jump_target_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] tmem [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_consumed = 0;
    int          ready_pct, gnt_pct, rv_pct, jump_pct;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] model_pc, model_fa;
    logic [31:0] last_addr, last_instr, last_req_addr;
    logic        consumed, granted, prev_jump, force_jump;
    logic [31:0] force_target;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] half(input logic [31:0] a);
        logic [31:0] w;
        w = tmem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction at a PC: compressed if the low halfword's bits[1:0] != 11.
    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        logic [15:0] lo;
        lo = half(a);
        if (lo[1:0] != 2'b11) return {16'h0000, lo};
        return {half(a + 32'd2), lo};
    endfunction

    function automatic logic [31:0] exp_len(input logic [31:0] a);
        logic [15:0] lo;
        lo = half(a);
        return (lo[1:0] != 2'b11) ? 32'd2 : 32'd4;
    endfunction

    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (force_jump) begin
            jump_i        = 1'b1;
            jump_target_i = force_target;
            force_jump    = 1'b0;
        end else if (jump_pct > 0 && $urandom_range(0, 99) < jump_pct) begin
            jump_i        = 1'b1;
            jump_target_i = 32'($urandom_range(0, 1023));
        end else begin
            jump_i = 1'b0;
        end
        instr_ready_i = ($urandom_range(0, 99) < ready_pct);
        if (pend && $urandom_range(0, 99) < rv_pct) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = tmem[pend_addr[9:2]];
            pend           = 1'b0;
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
        end
        instr_gnt_i = 1'b0;
        #1;
        consumed = 1'b0;
        granted  = 1'b0;
        if (!rst_n) begin
            chk("rst_req", instr_req_o, 0);
            chk("rst_valid", instr_valid_o, 0);
            chk("rst_instr", instr_o, 0);
            chk("rst_pc", instr_addr_o, RST_PC);
            chk("rst_fa", instr_mem_addr_o, RST_PC & ~32'd3);
            model_pc = RST_PC;
            model_fa = RST_PC & ~32'd3;
        end else begin
            if (prev_jump) chk("valid_after_jump", instr_valid_o, 0);
            if (jump_i) chk("req_during_jump", instr_req_o, 0);
            if (instr_valid_o && instr_ready_i && !jump_i) begin
                chk("instr_addr", instr_addr_o, model_pc);
                chk("instr", instr_o, exp_instr(model_pc));
                consumed   = 1'b1;
                last_addr  = instr_addr_o;
                last_instr = instr_o;
                model_pc   = model_pc + exp_len(model_pc);
                n_consumed++;
            end
            if (instr_req_o) begin
                chk("req_addr", instr_mem_addr_o, model_fa);
                if ($urandom_range(0, 99) < gnt_pct) begin
                    instr_gnt_i   = 1'b1;
                    pend          = 1'b1;
                    pend_addr     = instr_mem_addr_o;
                    granted       = 1'b1;
                    last_req_addr = instr_mem_addr_o;
                    model_fa      = model_fa + 32'd4;
                end
            end
            if (jump_i) begin
                model_pc = jump_target_i & ~32'd1;
                model_fa = jump_target_i & ~32'd3;
            end
        end
        prev_jump = jump_i && rst_n;
    endtask

    task automatic wait_consume(input string tag, input int limit);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!consumed && k < limit);
        chk({tag, "_timeout"}, consumed, 1);
    endtask

    task automatic wait_pend(input string tag);
        int k;
        k = 0;
        while (!pend && k < 20) begin
            cycle();
            k++;
        end
        chk({tag, "_pend"}, pend, 1);
    endtask

    initial begin
        int   jcyc;
        int   base;
        logic [31:0] hold;
        rst_n = 1'b0; instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0;
        instr_ready_i = 1'b0; jump_i = 1'b0; jump_target_i = '0;
        prev_jump = 1'b0; force_jump = 1'b0; force_target = '0;
        model_pc = RST_PC; model_fa = RST_PC;
        last_addr = '0; last_instr = '0; last_req_addr = '0;
        ready_pct = 100; gnt_pct = 100; rv_pct = 100; jump_pct = 0;
        for (int i = 0; i < 256; i++) tmem[i] = $urandom | 32'h0003_0003;

        // Reset, then a straight run of 32-bit instructions from RESET_ADDR
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        chk("t1_first_grant", granted, 1);
        chk("t1_first_req_addr", last_req_addr, RST_PC);
        wait_consume("t1_a", 10);
        chk("t1_a_addr", last_addr, RST_PC);
        wait_consume("t1_b", 10);
        chk("t1_b_addr", last_addr, RST_PC + 32'd4);
        repeat (16) cycle();

        // Two compressed halves in one word
        tmem[0] = 32'h0001_4501;
        force_jump = 1'b1; force_target = 32'h0;
        cycle(); jcyc = cyc;
        wait_consume("t2_a", 10);
        chk("t2_latency", 32'(cyc - jcyc), 3);
        chk("t2_a_addr", last_addr, 32'h0);
        chk("t2_a_instr", last_instr, 32'h0000_4501);
        cycle();
        chk("t2_b_cons", consumed, 1);
        chk("t2_b_addr", last_addr, 32'h2);
        chk("t2_b_instr", last_instr, 32'h0000_0001);
        repeat (6) cycle();

        // 32-bit instruction straddling a word boundary
        tmem[0] = 32'h0093_4501;
        tmem[1] = 32'hABCD_0000;
        force_jump = 1'b1; force_target = 32'h2;
        cycle(); jcyc = cyc;
        wait_consume("t3", 12);
        chk("t3_latency", 32'(cyc - jcyc), 5);
        chk("t3_addr", last_addr, 32'h2);
        chk("t3_instr", last_instr, 32'h0000_0093);
        repeat (6) cycle();

        // Redirect while a read is in flight: stale word must be dropped
        rv_pct = 0;
        wait_pend("t4");
        cycle();
        chk("t4_req_blocked", instr_req_o, 0);
        force_jump = 1'b1; force_target = 32'h206;
        cycle();
        rv_pct = 100;
        begin
            int k;
            k = 0;
            do begin cycle(); k++; end while (!granted && k < 10);
        end
        chk("t4_granted", granted, 1);
        chk("t4_req_addr", last_req_addr, 32'h204);
        wait_consume("t4", 10);
        chk("t4_first_addr", last_addr, 32'h206);
        repeat (6) cycle();

        // Decode stalled with the FIFO full
        force_jump = 1'b1; force_target = 32'h300;
        ready_pct = 0;
        repeat (10) cycle();
        hold = instr_o;
        chk("t5_valid", instr_valid_o, 1);
        chk("t5_hold_instr", hold, exp_instr(32'h300));
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_req_idle", instr_req_o, 0);
            chk("t5_instr_stable", instr_o, hold);
        end
        ready_pct = 100;
        base = n_consumed;
        repeat (20) cycle();
        chk("t5_progress", 32'(n_consumed - base >= 5), 1);

        // Reset between grant and rvalid; late rvalid must be ignored
        rv_pct = 0;
        wait_pend("t6");
        rst_n = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1;
        rv_pct = 100;
        wait_consume("t6", 12);
        chk("t6_first_addr", last_addr, RST_PC);

        // Randomized memory contents, handshake timing and redirects
        for (int i = 0; i < 256; i++) tmem[i] = $urandom;
        ready_pct = 70; gnt_pct = 60; rv_pct = 60; jump_pct = 3;
        base = n_consumed;
        repeat (3000) cycle();
        chk("rand_slow_progress", 32'(n_consumed - base > 100), 1);
        ready_pct = 80; gnt_pct = 100; rv_pct = 100; jump_pct = 5;
        base = n_consumed;
        repeat (1000) cycle();
        chk("rand_fast_progress", 32'(n_consumed - base > 100), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the decoder. Issues word-aligned read requests to instruction memory over a req/gnt/rvalid handshake, buffers returned words in a small FIFO, and realigns them into 32-bit or 16-bit (compressed) instructions at halfword-granular PCs. Presents one instruction per cycle with its address to decode under a valid/ready handshake. Flushes and refetches on control-transfer redirects.

## Interface
- RESET_ADDR, 32'h0000_0000: PC after reset; bit 0 must be 0.
- FIFO_DEPTH, 2: fetch-word buffer entries; at least 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_req_o  in→out  1  memory read request; held until granted.
- instr_mem_addr_o  out  RISCV_ADDR_WIDTH  word-aligned request address, bits [1:0] = 0.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  read data valid; exactly one per grant, earliest the cycle after grant.
- instr_rdata_i  in  RISCV_WORD_WIDTH  read data.
- instr_o  out  RISCV_WORD_WIDTH  aligned instruction; compressed ones zero-extended in [31:16].
- instr_addr_o  out  RISCV_ADDR_WIDTH  PC of instr_o.
- instr_valid_o  out  1  instr_o/instr_addr_o valid.
- instr_ready_i  in  1  decode consumes the instruction when valid && ready.
- jump_i  in  1  redirect request (jal/jalr/branch taken).
- jump_target_i  in  RISCV_ADDR_WIDTH  redirect PC; bit 0 ignored.

## Operation
- State: fetch address FA, PC, word FIFO (FIFO_DEPTH), outstanding flag (max one request in flight), discard flag.
- Request: instr_req_o = !outstanding && (FIFO entries + 0) < FIFO_DEPTH. On req && gnt: outstanding=1, FA += 4. On rvalid: outstanding=0; push rdata unless discard set, then clear discard instead.
- Realign (compressed = bits[1:0] != 2'b11):
  - PC[1]=0, head present: low half compressed → instr_o={16'b0,head[15:0]}, PC+=2, no pop. Else instr_o=head, PC+=4, pop.
  - PC[1]=1, head present: upper half compressed → {16'b0,head[31:16]}, PC+=2, pop. Else needs second entry; instr_o={next[15:0],head[31:16]}, PC+=4, pop one (next becomes head).
  - instr_valid_o = 0 when required words are not yet buffered.
- Advance PC/pop only on valid && ready; push and pop in the same cycle permitted at full.
- Redirect (jump_i): flush FIFO, PC=target&~1, FA=target&~3; if a request is in flight (granted, rvalid not yet seen, and not arriving this cycle) set discard. Jump has priority over consume and push in the same cycle; a request presented that cycle is not issued (instr_req_o forced 0).
- Reset: PC=RESET_ADDR, FA=RESET_ADDR&~3, FIFO empty, outstanding=0, discard=0.

## Timing
- Reset values: instr_req_o=0 while rst_n low, instr_mem_addr_o=RESET_ADDR&~3, instr_valid_o=0, instr_o=0, instr_addr_o=RESET_ADDR.
- First request in the first cycle after rst_n deasserts.
- Word returned on rvalid in cycle N is visible on instr_o in N+1 (registered FIFO, combinational realign).
- Redirect in cycle N: instr_valid_o=0 from N+1; request with new FA at N+1; zero-wait memory (gnt N+1, rvalid N+2) → valid instruction N+3.
- instr_req_o and instr_mem_addr_o stable until gnt; no combinational path from instr_gnt_i to instr_req_o.
- Reset asserted mid-transaction: all state cleared immediately; late rvalid after reset is ignored (outstanding=0, pushes only accepted while outstanding).

## Test plan
- Reset to RESET_ADDR=0x100, zero-wait memory returning 32-bit instrs → req addr 0x100,0x104,...; instr_addr_o 0x100,0x104 one per cycle after fill.
- Word 0x0001_4501 at 0x0 (two compressed halves) → instr_o 0x0000_4501 @0x0, then 0x0000_0001 @0x2, single pop.
- Halfword-misaligned 32-bit: word@0x0 = 0x0093_4501, word@0x4 = 0xXXXX_0000 with PC=0x2 → instr_o 0x0000_0093 assembled {0x0000,0x0093}@0x2, valid only after both words buffered.
- Jump to 0x206 while a request is outstanding → stale rvalid dropped, next req addr 0x204, first instr_addr_o 0x206.
- instr_ready_i low for 5 cycles with FIFO full → instr_req_o stays 0, instr_o stable, no data loss after ready rises.
- rst_n pulsed low between gnt and rvalid → late rvalid ignored, fetch restarts at RESET_ADDR.
